// File: rtl/int_responder.sv
// rtl/int_responder.sv - CPU-side interrupt responder for the IRQ / isr_addr / IACK handshake
//
// Takes a pending interrupt at an instruction boundary and saves the return
// PC. It pulses iack once while capturing isr_addr, redirects fetch to the
// ISR, and masks further interrupts until mret retires. It then redirects
// fetch back to the saved PC.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   irq, isr_addr    interrupt request level / ISR entry address (valid with iack)
//   iack             one-cycle interrupt acknowledge pulse
//   ie_wr, ie_wdata  global interrupt enable write strobe / value
//   retire, pc_next  instruction retires this cycle / address of following instruction
//   mret             retiring instruction is a return-from-interrupt
//   stall            holds fetch/retire while the handshake is in flight
//   redirect_valid   one-cycle pulse loading redirect_pc into the fetch PC
//   redirect_pc      fetch target while redirect_valid=1
//   in_isr           high from acceptance until the return redirect completes
//   ie, epc          global interrupt enable / saved return address

module int_responder #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              irq,
  input  logic [ADDR_W-1:0] isr_addr,
  output logic              iack,
  input  logic              ie_wr,
  input  logic              ie_wdata,
  input  logic              retire,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic              mret,
  output logic              stall,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              in_isr,
  output logic              ie,
  output logic [ADDR_W-1:0] epc
);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    ACK   = 3'd1,
    REDIR = 3'd2,
    ISR   = 3'd3,
    RET   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] target;
  logic              accept;

  // Only RUN looks at irq, so a stale irq level after iack cannot re-trigger.
  assign accept = (state == RUN) & irq & ie & retire & ~mret;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (accept) state_nxt = ACK;
      ACK:     state_nxt = REDIR;
      REDIR:   state_nxt = ISR;
      ISR:     if (retire && mret) state_nxt = RET;
      RET:     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Outputs are decoded from state and registered data only.
  always_comb begin
    iack           = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    in_isr         = 1'b0;
    case (state)
      ACK: begin
        iack   = 1'b1;
        stall  = 1'b1;
        in_isr = 1'b1;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = target;
        stall          = 1'b1;
        in_isr         = 1'b1;
      end
      ISR: begin
        in_isr = 1'b1;
      end
      RET: begin
        redirect_valid = 1'b1;
        redirect_pc    = epc;
        stall          = 1'b1;
        in_isr         = 1'b1;
      end
      default: ;
    endcase
  end

  // Enable, return address and ISR target registers.
  // accept uses the pre-edge ie, so a same-cycle ie clear does not cancel it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie     <= 1'b0;
      epc    <= '0;
      target <= '0;
    end else begin
      if (ie_wr) ie <= ie_wdata;
      if (accept) epc <= pc_next;
      if (state == ACK) target <= isr_addr;
    end
  end

endmodule

// File: doc/int_responder.md
# int_responder

CPU-side responder for the interrupt controller's IRQ / isr_addr / IACK handshake. It sits in the processor between retire and fetch. It takes a pending IRQ only at an instruction boundary and saves the return PC. It then pulses IACK exactly once while sampling isr_addr, redirects fetch to the ISR, masks further interrupts until `mret` retires, and finally redirects fetch back to the saved PC.

## Interface
Parameters:
- ADDR_W, 32, width of PC and ISR addresses

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- irq  in  1  interrupt request from the interrupt controller; level, may lag IACK by up to 2 cycles
- isr_addr  in  ADDR_W  ISR entry address from the interrupt controller; valid in the cycle iack=1
- iack  out  1  interrupt acknowledge; one-cycle pulse
- ie_wr  in  1  write strobe for the global interrupt enable
- ie_wdata  in  1  new global interrupt enable value
- retire  in  1  an instruction completes this cycle
- pc_next  in  ADDR_W  address of the instruction following the retiring one; valid when retire=1
- mret  in  1  the retiring instruction is a return-from-interrupt; meaningful only with retire=1
- stall  out  1  holds fetch/retire while the handshake is in flight
- redirect_valid  out  1  one-cycle pulse that loads redirect_pc into the fetch PC
- redirect_pc  out  ADDR_W  fetch target while redirect_valid=1
- in_isr  out  1  high from acceptance until the return redirect completes
- ie  out  1  current global interrupt enable
- epc  out  ADDR_W  saved return address

## Operation
- FSM states: RUN, ACK, REDIR, ISR, RET. Reset state is RUN.
- Reset values: iack=0, stall=0, redirect_valid=0, redirect_pc=0, in_isr=0, ie=0, epc=0, and the internal target register =0.
- ie register:
  - ie_wr=1 loads ie_wdata on the next edge, in any state.
  - A write is legal during an ISR, but ie gates acceptance only in RUN.
- RUN:
  - Accept condition: irq & ie & retire & ~mret.
  - On accept: epc<=pc_next, go to ACK.
  - retire with mret in RUN is ignored (no redirect, no state change).
- ACK (one cycle):
  - iack=1, stall=1.
  - target<=isr_addr, sampled in this same cycle.
  - Go to REDIR.
- REDIR (one cycle):
  - redirect_valid=1, redirect_pc=target, stall=1.
  - Go to ISR.
- ISR:
  - irq is ignored; no nesting.
  - retire & mret -> go to RET.
  - A plain retire has no effect.
- RET (one cycle):
  - redirect_valid=1, redirect_pc=epc, stall=1.
  - Go to RUN.
- retire and mret are ignored in ACK, REDIR and RET. The pipeline is stalled in these states; inputs are don't-care.
- in_isr=1 in ACK, REDIR, ISR and RET.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.
- iack is asserted at most once per accepted interrupt. Stale irq after iack is masked because the FSM has already left RUN.

## Timing
- Cycle T (RUN): retire=1, irq=1, ie=1.
- T+1: iack=1, stall=1, in_isr=1; epc holds pc_next from T.
- T+2: redirect_valid=1 with redirect_pc = the isr_addr sampled at T+1.
- T+3: state ISR; stall=0.
- Retire-to-redirect latency is 2 cycles.
- Cycle U (ISR): retire=1, mret=1.
- U+1: redirect_valid=1, redirect_pc=epc.
- U+2: state RUN, in_isr=0.
- The earliest next acceptance is at U+2, on the first retire with irq still high.
- irq high without retire, or with ie=0: wait in RUN indefinitely, with no iack.
- ie_wr clearing ie in the same cycle as an accept condition: accept still proceeds, because it uses the pre-edge ie.
- rst_n low in any state: immediate asynchronous return to RUN with all reset values. An in-flight iack or redirect is dropped.
- After rst_n deasserts, the first accept requires a prior ie_wr.

## Test plan
- Basic take:
  - Stimulus: ie set; irq=1; retire at T with pc_next=0x100; isr_addr=0x800 at T+1.
  - Required: iack pulse only at T+1; redirect 0x800 at T+2; epc=0x100; in_isr=1.
- Return:
  - Stimulus: from the ISR state, retire with mret at U.
  - Required: redirect_valid=1 with redirect_pc=0x100 at U+1; in_isr=0 and state RUN at U+2.
- Masking:
  - Stimulus: ie=0, irq=1, 10 retires.
  - Required: no iack and no redirect.
  - Stimulus: then ie_wr=1, ie_wdata=1, then the next retire.
  - Required: accept, with iack exactly 2 cycles later.
- No nesting / stale irq:
  - Stimulus: irq held high through ISR entry and through 5 retires inside the ISR.
  - Required: a single iack total until mret.
  - Required after return: the next retire with irq=1 produces a new iack.
- Boundary:
  - Stimulus: mret+retire while in RUN.
  - Required: ignored.
  - Stimulus: isr_addr changes to 0x900 at T+2.
  - Required: redirect_pc stays 0x800.
- Reset mid-handshake:
  - Stimulus: rst_n low during ACK.
  - Required: iack drops immediately; all outputs at reset values; ie=0.
